// File: rtl/seq_multiply.sv
// Sequential unsigned shift-add multiplier: A/Q/M datapath, one partial-product bit per clock.
// Shares the start/busy/done handshake of the companion restoring divider.
module seq_multiply #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH:0]       a_q, a_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [WIDTH:0]       sum_s;
  logic [WIDTH:0]       a_next_s;
  logic [WIDTH-1:0]     q_next_s;

  // Conditional add of M into A, keeping the carry in A[WIDTH].
  function automatic logic [WIDTH:0] partial_sum(input logic [WIDTH:0]   a,
                                                 input logic [WIDTH-1:0] m,
                                                 input logic             q0);
    logic [WIDTH:0] s;
    if (q0) begin
      s = a + {1'b0, m};
    end else begin
      s = a;
    end
    return s;
  endfunction

  // One iteration: {A,Q} <= {1'b0,sum,Q} >> 1.
  always_comb begin
    sum_s    = partial_sum(a_q, m_q, q_q[0]);
    a_next_s = {1'b0, sum_s[WIDTH:1]};
    q_next_s = {sum_s[0], q_q[WIDTH-1:1]};
  end

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    m_d       = m_q;
    count_d   = count_q;
    product_d = product_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = multiplicand;
          q_d     = multiplier;
          a_d     = '0;
          count_d = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_next_s;
        q_d     = q_next_s;
        count_d = count_q + CW'(1);
        if (count_q == LAST_COUNT) begin
          // Product is captured on the very edge that enters DONE.
          product_d = {a_next_s[WIDTH-1:0], q_next_s};
          state_d   = DONE;
        end else begin
          state_d   = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      q_q       <= '0;
      m_q       <= '0;
      count_q   <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      m_q       <= m_d;
      count_q   <= count_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule
